regfile_write_ctrl: RTL and testbench

//   Initiator for the register file write port: accepts write requests over a valid/ready

---
 rtl/regfile_write_ctrl.sv | 105 ++++++++++
 tb/tb_regfile_write_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_ctrl.sv
// Register-file write initiator: captures a request, writes it, reads it back to
// verify, rewrites on mismatch up to MAX_RETRY times, then returns a status response.
module regfile_write_ctrl #(
  parameter int DATA_WIDTH   = 4,
  parameter int ADDR_WIDTH   = 2,
  parameter int MAX_RETRY    = 2,
  parameter int RETRY_WIDTH  = 2,
  parameter int ERRCNT_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_data,
  output logic                    rf_wr_en,
  output logic [ADDR_WIDTH-1:0]   rf_wr_addr,
  output logic [DATA_WIDTH-1:0]   rf_wr_data,
  output logic [ADDR_WIDTH-1:0]   rf_rd_addr,
  input  logic [DATA_WIDTH-1:0]   rf_rd_data,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic                    resp_err,
  output logic [RETRY_WIDTH-1:0]  resp_retries,
  output logic [ERRCNT_WIDTH-1:0] err_count
);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_VERIFY, S_RESP} state_t;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   cap_addr, cap_addr_nxt;
  logic [DATA_WIDTH-1:0]   cap_data, cap_data_nxt;
  logic [RETRY_WIDTH-1:0]  retry_cnt, retry_cnt_nxt;
  logic [ERRCNT_WIDTH-1:0] err_cnt_q, err_cnt_nxt;
  logic                    resp_err_q, resp_err_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cap_addr   <= '0;
      cap_data   <= '0;
      retry_cnt  <= '0;
      err_cnt_q  <= '0;
      resp_err_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      cap_addr   <= cap_addr_nxt;
      cap_data   <= cap_data_nxt;
      retry_cnt  <= retry_cnt_nxt;
      err_cnt_q  <= err_cnt_nxt;
      resp_err_q <= resp_err_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cap_addr_nxt  = cap_addr;
    cap_data_nxt  = cap_data;
    retry_cnt_nxt = retry_cnt;
    err_cnt_nxt   = err_cnt_q;
    resp_err_nxt  = resp_err_q;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          cap_addr_nxt  = req_addr;
          cap_data_nxt  = req_data;
          retry_cnt_nxt = '0;
          state_nxt     = S_WRITE;
        end
      end
      S_WRITE: state_nxt = S_VERIFY;
      S_VERIFY: begin
        if (rf_rd_data == cap_data) begin
          resp_err_nxt = 1'b0;
          state_nxt    = S_RESP;
        end else if (retry_cnt < RETRY_WIDTH'(MAX_RETRY)) begin
          retry_cnt_nxt = retry_cnt + RETRY_WIDTH'(1);
          state_nxt     = S_WRITE;
        end else begin
          // Out of retries: report failure and bump the saturating error count.
          resp_err_nxt = 1'b1;
          if (err_cnt_q != '1)
            err_cnt_nxt = err_cnt_q + ERRCNT_WIDTH'(1);
          state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (resp_ready)
          state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign req_ready    = (state == S_IDLE);
  assign rf_wr_en     = (state == S_WRITE);
  assign resp_valid   = (state == S_RESP);
  assign rf_wr_addr   = cap_addr;
  assign rf_rd_addr   = cap_addr;
  assign rf_wr_data   = cap_data;
  assign resp_err     = resp_err_q;
  assign resp_retries = retry_cnt;
  assign err_count    = err_cnt_q;

endmodule

// File: tb/tb_regfile_write_ctrl.sv
// Scoreboard bench for regfile_write_ctrl with a register-file model that can
// force stuck-at-0 bits, so verify failures and retries can be provoked.
module tb_regfile_write_ctrl;

  localparam int DW = 4;
  localparam int AW = 2;
  localparam int MR = 2;
  localparam int RW = 2;
  localparam int EW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_data = '0;
  logic          rf_wr_en;
  logic [AW-1:0] rf_wr_addr;
  logic [DW-1:0] rf_wr_data;
  logic [AW-1:0] rf_rd_addr;
  logic [DW-1:0] rf_rd_data;
  logic          resp_valid;
  logic          resp_ready = 1'b1;
  logic          resp_err;
  logic [RW-1:0] resp_retries;
  logic [EW-1:0] err_count;

  regfile_write_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_RETRY(MR),
    .RETRY_WIDTH(RW), .ERRCNT_WIDTH(EW)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_err(resp_err), .resp_retries(resp_retries), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Register file model; bits set in stuck0 never store a 1.
  logic [DW-1:0] mem [4] = '{default: '0};
  logic [DW-1:0] stuck0 = '0;
  always @(posedge clk) if (rf_wr_en) mem[rf_wr_addr] <= rf_wr_data & ~stuck0;
  assign rf_rd_data = mem[rf_rd_addr];

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          err;
    logic [RW-1:0] retries;
    logic [EW-1:0] errcnt;
    int            acc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   pulses = 0;
  bit   seen = 0;
  bit   running = 0;
  bit   rr_rand = 0;
  int   model_errcnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Issue one request and push the expected outcome once it is accepted.
  task automatic issue(input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_t e;
    int   n = 0;
    req_valid = 1'b1;
    req_addr  = a;
    req_data  = d;
    forever begin
      @(negedge clk); #1;
      if (req_ready) break;
      n++;
      if (n > 100) begin
        chk("accept_timeout", 32'd0, 32'd1);
        return;
      end
    end
    e.addr = a;
    e.data = d;
    e.acc  = cyc + 1;
    if ((d & stuck0) == '0) begin
      e.err     = 1'b0;
      e.retries = '0;
    end else begin
      e.err     = 1'b1;
      e.retries = RW'(MR);
      if (model_errcnt < (1 << EW) - 1) model_errcnt++;
    end
    e.errcnt = EW'(model_errcnt);
    q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (q.size() != 0) begin
      @(posedge clk); #1;
      n++;
      if (n > 300) begin
        chk("drain_timeout", 32'(q.size()), 32'd0);
        return;
      end
    end
  endtask

  // Monitor: compares every presented write pulse and response to the queue head.
  always @(negedge clk) begin
    if (running && !rst) begin
      chk("req_ready", 32'(req_ready), 32'(q.size() == 0));
      if (rf_wr_en) begin
        if (q.size() == 0) chk("spurious_write", 32'd1, 32'd0);
        else begin
          chk("wr_addr", 32'(rf_wr_addr), 32'(q[0].addr));
          chk("wr_data", 32'(rf_wr_data), 32'(q[0].data));
          chk("rd_addr", 32'(rf_rd_addr), 32'(q[0].addr));
          pulses++;
        end
      end
      if (seen && !resp_valid) begin
        chk("resp_withdrawn", 32'd0, 32'd1);
        seen = 0;
      end
      if (resp_valid) begin
        if (q.size() == 0) chk("spurious_resp", 32'd1, 32'd0);
        else begin
          if (!seen) begin
            chk("resp_latency", 32'(cyc), 32'(q[0].acc + 2 + 2 * int'(q[0].retries)));
            seen = 1;
          end
          chk("resp_err", 32'(resp_err), 32'(q[0].err));
          chk("resp_retries", 32'(resp_retries), 32'(q[0].retries));
          chk("err_count", 32'(err_count), 32'(q[0].errcnt));
          if (resp_ready) begin
            chk("write_pulses", 32'(pulses), 32'(q[0].retries) + 32'd1);
            void'(q.pop_front());
            pulses = 0;
            seen = 0;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rr_rand) resp_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_wr_en", 32'(rf_wr_en), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_wr_addr", 32'(rf_wr_addr), 32'd0);
    chk("rst_rd_addr", 32'(rf_rd_addr), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    running = 1;
    @(posedge clk); #1;

    // Single clean write
    issue(2'd2, 4'h9);
    req_valid = 1'b0;
    wait_idle();

    // Back-to-back with valid held high
    issue(2'd1, 4'h3);
    issue(2'd3, 4'hC);
    req_valid = 1'b0;
    wait_idle();

    // Stuck bit0: odd data exhausts retries, even data passes
    stuck0 = 4'h1;
    issue(2'd0, 4'hB);
    req_valid = 1'b0;
    wait_idle();
    issue(2'd0, 4'hA);
    req_valid = 1'b0;
    wait_idle();
    stuck0 = 4'h0;

    // Response stalled for 5 cycles with a competing request pending
    resp_ready = 1'b0;
    issue(2'd0, 4'h5);
    req_addr = 2'd2;
    req_data = 4'h7;
    repeat (7) @(posedge clk);
    #1 resp_ready = 1'b1;
    issue(2'd2, 4'h7);
    req_valid = 1'b0;
    wait_idle();

    // Random traffic with random stuck masks and response back-pressure
    rr_rand = 1;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        req_valid = 1'b0;
        wait_idle();
        stuck0 = ($urandom_range(0, 1) == 0) ? 4'h0 : DW'($urandom_range(0, 15));
      end
      issue(AW'($urandom_range(0, 3)), DW'($urandom_range(0, 15)));
      if ($urandom_range(0, 2) == 0) begin
        req_valid = 1'b0;
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
      end
    end
    req_valid = 1'b0;
    wait_idle();
    rr_rand = 0;
    #1 resp_ready = 1'b1;
    stuck0 = 4'h0;

    // Reset during the write pulse drops the request
    issue(2'd3, 4'h6);
    req_valid = 1'b0;
    chk("pre_rst_wr_en", 32'(rf_wr_en), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete();
    pulses = 0;
    seen = 0;
    model_errcnt = 0;
    @(negedge clk);
    chk("mid_rst_wr_en", 32'(rf_wr_en), 32'd0);
    chk("mid_rst_req_ready", 32'(req_ready), 32'd1);
    chk("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("mid_rst_err_count", 32'(err_count), 32'd0);
    @(posedge clk); #1;

    // 20 failing requests saturate err_count
    stuck0 = 4'h1;
    for (int i = 0; i < 20; i++) begin
      issue(AW'(i % 4), DW'((2 * i + 1) % 16));
      req_valid = 1'b0;
    end
    wait_idle();
    @(negedge clk);
    chk("err_count_sat", 32'(err_count), 32'hF);
    chk("queue_empty", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
